// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Arbitrates register-file writeback between three sources (0=ALU, 1=LSU,
// 2=MUL/DIV). It accepts one source per cycle and registers the accepted
// rd/data into a single write port with one cycle of latency. Writes to x0
// complete their handshake but are dropped at the write port.
//
// Configuration macro: RF_WB_RR_ARB_EN
//   defined   -> round-robin arbitration. The search starts after the last
//                granted source.
//   undefined -> fixed priority. Source 0 is highest and source 2 is lowest.
//                No pointer register is built.
//
// Ports
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   req_valid       : per-source writeback request            [NUM_REQ]
//   req_rd_addr     : per-source rd, source i at [i*ADDR_W +: ADDR_W]
//   req_data        : per-source data, packed like req_rd_addr
//   req_ready       : per-source accept (combinational)       [NUM_REQ]
//   rf_write_enable : register-file write strobe
//   rf_rd_addr      : register-file write index
//   rf_data_in      : register-file write data
//   pending_mask    : one-hot of the register written this cycle (combinational)
//   commit_count    : saturating count of issued writes
module rf_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_REQ = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    output logic [DATA_W-1:0]         rf_data_in,
    output logic [31:0]               pending_mask,
    output logic [15:0]               commit_count
);

    // Converts a one-hot grant into a source index. An empty grant maps to 0,
    // but the handshake qualifier blocks that case anyway.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] g);
        logic [1:0] idx;
        case (g)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

`ifdef RF_WB_RR_ARB_EN
    // Returns the first valid source found when searching from 'start' and
    // wrapping modulo 3.
    function automatic logic [NUM_REQ-1:0] first_from(input logic [NUM_REQ-1:0] valid,
                                                      input logic [1:0]         start);
        logic [NUM_REQ-1:0] g;
        logic               found;
        logic [2:0]         sum;
        logic [1:0]         idx;
        g     = {NUM_REQ{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start} + 3'(k);
            if (sum >= 3'd3) begin
                sum = sum - 3'd3;
            end else begin
                sum = sum;
            end
            idx = sum[1:0];
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

    logic [1:0] last_grant_r;
    logic [1:0] next_start_s;

    // Round-robin search start: the source after the last grant.
    always_comb begin
        next_start_s = 2'd0;
        if (last_grant_r == 2'd2) begin
            next_start_s = 2'd0;
        end else begin
            next_start_s = last_grant_r + 2'd1;
        end
    end
`endif

    logic [NUM_REQ-1:0] grant_s;
    logic [1:0]         sel_idx_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               hs_s;
    logic               wr_next_s;

    logic               wr_en_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic [DATA_W-1:0]  data_r;
    logic [15:0]        count_r;

    // Grant selection. Reset masks every grant, so no handshake happens in reset.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        if (rst) begin
            grant_s = {NUM_REQ{1'b0}};
        end else begin
`ifdef RF_WB_RR_ARB_EN
            grant_s = first_from(req_valid, next_start_s);
`else
            // Isolate the lowest set bit. This gives source 0 the highest priority.
            grant_s = req_valid & (~req_valid + {{(NUM_REQ-1){1'b0}}, 1'b1});
`endif
        end
    end

    assign req_ready = grant_s;

    // Selects the accepted source's rd/data and decides whether it writes.
    always_comb begin
        sel_idx_s  = onehot_to_idx(grant_s);
        sel_addr_s = req_rd_addr[sel_idx_s*ADDR_W +: ADDR_W];
        sel_data_s = req_data[sel_idx_s*DATA_W +: DATA_W];
        hs_s       = |(req_valid & grant_s);
        wr_next_s  = hs_s && (sel_addr_s != {ADDR_W{1'b0}});
    end

`ifdef RF_WB_RR_ARB_EN
    // Remembers the last granted source. After reset it points at 2, so the
    // first search starts at source 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 2'd2;
        end else if (hs_s) begin
            last_grant_r <= sel_idx_s;
        end
    end
`endif

    // Output stage: registers the accepted write and holds rd/data when idle.
    // The counter advances on the same edge that raises write enable, so it
    // already includes the write being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            count_r   <= 16'd0;
        end else if (hs_s) begin
            wr_en_r   <= wr_next_s;
            rd_addr_r <= sel_addr_s;
            data_r    <= sel_data_s;
            if (wr_next_s && (count_r != 16'hFFFF)) begin
                count_r <= count_r + 16'd1;
            end
        end else begin
            wr_en_r <= 1'b0;
        end
    end

    // One-hot hazard flag for the register being written this cycle.
    always_comb begin
        pending_mask = 32'd0;
        if (wr_en_r) begin
            pending_mask = 32'd1 << rd_addr_r;
        end else begin
            pending_mask = 32'd0;
        end
    end

    assign rf_write_enable = wr_en_r;
    assign rf_rd_addr      = rd_addr_r;
    assign rf_data_in      = data_r;
    assign commit_count    = count_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_rd_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_data_in;
    logic [31:0] pending_mask;
    logic [15:0] commit_count;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REQ(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd_addr(req_rd_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_write_enable(rf_write_enable),
        .rf_rd_addr(rf_rd_addr), .rf_data_in(rf_data_in), .pending_mask(pending_mask),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 3'b111;
        req_rd_addr = {5'd3, 5'd2, 5'd1}; req_data = {32'hC, 32'hB, 32'hA};
        #1;
        checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready_pre: got %b expected 000", req_ready); end
        tick(); tick();
        checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", rf_write_enable); end
        checks++; if (rf_rd_addr !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d expected 0", rf_rd_addr); end
        checks++; if (rf_data_in !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", rf_data_in); end
        checks++; if (commit_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", commit_count); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL reset_mask: got %h expected 0", pending_mask); end
        req_valid = 3'b000;
        exp_count = 0;
    endtask

    task automatic test_single_write();
        rst = 1'b0; req_valid = 3'b001;
        req_rd_addr = {5'd0, 5'd0, 5'd5}; req_data = {32'd0, 32'd0, 32'hDEADBEEF};
        #1;
        checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready: got %b expected 001", req_ready); end
        tick();
        req_valid = 3'b000; exp_count++;
        checks++; if (rf_write_enable !== 1'b1) begin failures++; $display("FAIL single_we: got %b expected 1", rf_write_enable); end
        checks++; if (rf_rd_addr !== 5'd5) begin failures++; $display("FAIL single_rd: got %0d expected 5", rf_rd_addr); end
        checks++; if (rf_data_in !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h expected deadbeef", rf_data_in); end
        checks++; if (pending_mask !== 32'h20) begin failures++; $display("FAIL single_mask: got %h expected 00000020", pending_mask); end
        checks++; if (commit_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", commit_count); end
        tick();
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL idle_we: got %b expected 0", rf_write_enable); end
        checks++; if (rf_rd_addr !== 5'd5 || rf_data_in !== 32'hDEADBEEF) begin failures++; $display("FAIL idle_hold: got rd=%0d data=%h expected rd=5 data=deadbeef", rf_rd_addr, rf_data_in); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL idle_mask: got %h expected 0", pending_mask); end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_rdy [3];
        logic [4:0]  exp_rd  [3];
        rst = 1'b1; tick(); tick(); rst = 1'b0; exp_count = 0;
        req_valid = 3'b111;
        req_rd_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC0000003, 32'hB0000002, 32'hA0000001};
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== (3'b001 << k)) begin failures++; $display("FAIL contend_ready%0d: got %b expected %b", k, req_ready, 3'b001 << k); end
            tick();
            req_valid[k] = 1'b0; exp_count++;
            checks++; if (rf_write_enable !== 1'b1 || rf_rd_addr !== 5'(k + 1)) begin failures++; $display("FAIL contend_write%0d: got we=%b rd=%0d expected we=1 rd=%0d", k, rf_write_enable, rf_rd_addr, k + 1); end
            checks++; if (commit_count !== 16'(exp_count)) begin failures++; $display("FAIL contend_count%0d: got %0d expected %0d", k, commit_count, exp_count); end
        end
        tick();
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL contend_idle: got %b expected 0", rf_write_enable); end
        // Source 0 stays valid throughout; sources 1 and 2 drop after their grant.
`ifdef RF_WB_RR_ARB_EN
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3;
`else
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b001; exp_rdy[2] = 3'b001;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd1; exp_rd[2] = 5'd1;
`endif
        req_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== exp_rdy[k]) begin failures++; $display("FAIL fairness_ready%0d: got %b expected %b", k, req_ready, exp_rdy[k]); end
            tick();
            if (exp_rdy[k] == 3'b010) req_valid[1] = 1'b0;
            else if (exp_rdy[k] == 3'b100) req_valid[2] = 1'b0;
            exp_count++;
            checks++; if (rf_rd_addr !== exp_rd[k]) begin failures++; $display("FAIL fairness_rd%0d: got %0d expected %0d", k, rf_rd_addr, exp_rd[k]); end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_x0();
        req_valid = 3'b010;
        req_rd_addr = {5'd0, 5'd0, 5'd0}; req_data = {32'd0, 32'h1234, 32'd0};
        #1;
        checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready: got %b expected 010", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL x0_we: got %b expected 0", rf_write_enable); end
        checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL x0_mask: got %h expected 0", pending_mask); end
        checks++; if (commit_count !== 16'(exp_count)) begin failures++; $display("FAIL x0_count: got %0d expected %0d", commit_count, exp_count); end
        checks++; if (rf_rd_addr !== 5'd0 || rf_data_in !== 32'h1234) begin failures++; $display("FAIL x0_regs: got rd=%0d data=%h expected rd=0 data=00001234", rf_rd_addr, rf_data_in); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rds [3];
        rds[0] = 5'd7; rds[1] = 5'd8; rds[2] = 5'd9;
        req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            req_rd_addr = {5'd0, 5'd0, rds[k]};
            req_data = {32'd0, 32'd0, 32'h70 + 32'(k) * 32'h10};
            #1;
            checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL b2b_ready%0d: got %b expected 001", k, req_ready); end
            tick();
            exp_count++;
            checks++; if (rf_write_enable !== 1'b1 || rf_rd_addr !== rds[k] || rf_data_in !== 32'h70 + 32'(k) * 32'h10)
                begin failures++; $display("FAIL b2b_write%0d: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h", k, rf_write_enable, rf_rd_addr, rf_data_in, rds[k], 32'h70 + 32'(k) * 32'h10); end
            checks++; if (pending_mask !== (32'd1 << rds[k])) begin failures++; $display("FAIL b2b_mask%0d: got %h expected %h", k, pending_mask, 32'd1 << rds[k]); end
        end
        // Same rd from two sources on successive cycles: the later grant's data lands last.
        req_valid = 3'b010;
        req_rd_addr = {5'd4, 5'd4, 5'd0}; req_data = {32'h44442222, 32'h44441111, 32'd0};
        tick();
        req_valid = 3'b100; exp_count++;
        checks++; if (rf_write_enable !== 1'b1 || rf_rd_addr !== 5'd4 || rf_data_in !== 32'h44441111) begin failures++; $display("FAIL same_rd_first: got we=%b rd=%0d data=%h expected we=1 rd=4 data=44441111", rf_write_enable, rf_rd_addr, rf_data_in); end
        tick();
        req_valid = 3'b000; exp_count++;
        checks++; if (rf_write_enable !== 1'b1 || rf_rd_addr !== 5'd4 || rf_data_in !== 32'h44442222) begin failures++; $display("FAIL same_rd_second: got we=%b rd=%0d data=%h expected we=1 rd=4 data=44442222", rf_write_enable, rf_rd_addr, rf_data_in); end
        checks++; if (commit_count !== 16'(exp_count)) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", commit_count, exp_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b100;
        req_rd_addr = {5'd6, 5'd0, 5'd0}; req_data = {32'h66, 32'd0, 32'd0};
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rstmid_ready: got %b expected 000", req_ready); end
        tick();
        exp_count = 0;
        checks++; if (rf_write_enable !== 1'b0 || commit_count !== 16'd0) begin failures++; $display("FAIL rstmid_state: got we=%b count=%0d expected we=0 count=0", rf_write_enable, commit_count); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL rstmid_rearb: got %b expected 100", req_ready); end
        tick();
        req_valid = 3'b000; exp_count++;
        checks++; if (rf_write_enable !== 1'b1 || rf_rd_addr !== 5'd6 || commit_count !== 16'd1) begin failures++; $display("FAIL rstmid_write: got we=%b rd=%0d count=%0d expected we=1 rd=6 count=1", rf_write_enable, rf_rd_addr, commit_count); end
        tick();
    endtask

    task automatic test_saturation();
        req_valid = 3'b001;
        req_rd_addr = {5'd0, 5'd0, 5'd1}; req_data = {32'd0, 32'd0, 32'h5A5A5A5A};
        while (exp_count < 65535) begin
            tick();
            exp_count++;
        end
        checks++; if (commit_count !== 16'hFFFF) begin failures++; $display("FAIL sat_preload: got %h expected ffff", commit_count); end
        tick(); tick();
        checks++; if (commit_count !== 16'hFFFF || rf_write_enable !== 1'b1) begin failures++; $display("FAIL sat_hold: got count=%h we=%b expected count=ffff we=1", commit_count, rf_write_enable); end
        req_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 3'b000; req_rd_addr = 15'd0; req_data = 96'd0;
        test_reset();
        test_single_write();
        test_contention();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
